// File: rtl/fp_pkg.sv
// Shared constants, flag indices and operand-class type for the FP multiply pipe.
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [30:0] FP_INF_MAG = 31'h7F80_0000;

    localparam int FLG_INVALID = 0;
    localparam int FLG_INF     = 1;
    localparam int FLG_ZERO    = 2;
    localparam int FLG_NAN     = 3;

    typedef struct packed {
        logic is_nan;
        logic is_inf;
        logic is_zero;
    } fp_class_t;

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Operand-issue / result-writeback bundle of the FP multiply pipe.
interface fp_mul_pipe_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [3:0]        out_flags;
    logic              flag_clr;
    logic [3:0]        sticky_flags;
    logic [CNT_W-1:0]  op_count;

    modport master (
        output in_valid, in_a, in_b, out_ready, flag_clr,
        input  in_ready, out_valid, out_result, out_flags, sticky_flags, op_count
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready, flag_clr,
        output in_ready, out_valid, out_result, out_flags, sticky_flags, op_count
    );
endinterface

// File: rtl/fp_classify.sv
// Classifies one single-precision operand as zero, infinity or NaN.
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0] op,
    output fp_class_t   cls
);
    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic             unused_sign;

    assign exp_f       = op[30:23];
    assign man_f       = op[22:0];
    assign unused_sign = op[31];

    assign cls.is_nan  = (exp_f == '1) && (man_f != '0);
    assign cls.is_inf  = (exp_f == '1) && (man_f == '0);
    assign cls.is_zero = (exp_f == '0) && (man_f == '0);
endmodule

// File: rtl/fp_multiplier.sv
// Combinational single-precision multiplier, round-to-nearest-even, flush-to-zero on underflow.
module fp_multiplier (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);
    logic               sgn;
    logic [23:0]        man_a, man_b;
    logic [47:0]        prod;
    logic signed [9:0]  exp_s;
    logic [22:0]        mant;
    logic               guard, sticky;
    logic [23:0]        mant_r;

    always_comb begin
        sgn    = a[31] ^ b[31];
        man_a  = {|a[30:23], a[22:0]};
        man_b  = {|b[30:23], b[22:0]};
        prod   = {24'd0, man_a} * {24'd0, man_b};
        exp_s  = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        // Product of two 1.x mantissas lies in [1,4): one normalising shift at most
        if (prod[47]) begin
            mant   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            exp_s  = exp_s + 10'sd1;
        end else begin
            mant   = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end
        mant_r = {1'b0, mant} + {23'd0, guard & (sticky | mant[0])};
        if (mant_r[23]) begin
            exp_s = exp_s + 10'sd1;
        end
        if (exp_s >= 10'sd255) begin
            result = {sgn, 8'hFF, 23'd0};
        end else if (exp_s <= 10'sd0) begin
            result = {sgn, 31'd0};
        end else begin
            result = {sgn, exp_s[7:0], mant_r[22:0]};
        end
    end
endmodule

// File: rtl/fp_mul_pipe.sv
// Two-stage valid/ready pipeline around fp_multiplier with special-case overrides and flags.
// Optional sticky-flag register enabled by defining FP_MUL_STICKY_FLAGS_EN.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    fp_mul_pipe_if.slave  bus
);
    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    fp_class_t         s1_cls_a_q, s1_cls_a_d, s1_cls_b_q, s1_cls_b_d;
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_result_q, s2_result_d;
    logic [3:0]        s2_flags_q, s2_flags_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;

    logic              s1_adv, s2_adv, out_xfer;
    logic [DATA_W-1:0] op_in [2];
    fp_class_t         cls_in [2];
    logic [31:0]       raw_product;
    logic [DATA_W-1:0] ovr_result;
    logic [3:0]        ovr_flags;
    logic              sgn;

    assign op_in[0] = bus.in_a;
    assign op_in[1] = bus.in_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cls
            fp_classify u_cls (.op(op_in[gi]), .cls(cls_in[gi]));
        end
    endgenerate

    fp_multiplier u_mul (.a(s1_a_q), .b(s1_b_q), .result(raw_product));

    assign s2_adv       = !s2_valid_q || bus.out_ready;
    assign s1_adv       = !s1_valid_q || s2_adv;
    assign out_xfer     = s2_valid_q && bus.out_ready;
    assign bus.in_ready = s1_adv;

    always_comb begin
        sgn        = s1_a_q[31] ^ s1_b_q[31];
        ovr_result = raw_product;
        ovr_flags  = 4'd0;
        if (s1_cls_a_q.is_nan || s1_cls_b_q.is_nan) begin
            ovr_result             = FP_QNAN;
            ovr_flags[FLG_INVALID] = 1'b1;
            ovr_flags[FLG_NAN]     = 1'b1;
        end else if ((s1_cls_a_q.is_zero && s1_cls_b_q.is_inf) ||
                     (s1_cls_a_q.is_inf && s1_cls_b_q.is_zero)) begin
            ovr_result             = FP_QNAN;
            ovr_flags[FLG_INVALID] = 1'b1;
        end else if (s1_cls_a_q.is_inf || s1_cls_b_q.is_inf) begin
            ovr_result         = {sgn, FP_INF_MAG};
            ovr_flags[FLG_INF] = 1'b1;
        end else if (s1_cls_a_q.is_zero || s1_cls_b_q.is_zero) begin
            ovr_result          = {sgn, 31'd0};
            ovr_flags[FLG_ZERO] = 1'b1;
        end else begin
            ovr_flags[FLG_ZERO] = (raw_product[30:0] == 31'd0);
            ovr_flags[FLG_INF]  = (raw_product[30:0] == FP_INF_MAG);
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_cls_a_d  = s1_cls_a_q;
        s1_cls_b_d  = s1_cls_b_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_flags_d  = s2_flags_q;
        op_count_d  = out_xfer ? op_count_q + {{(CNT_W-1){1'b0}}, 1'b1} : op_count_q;
        if (s1_adv) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_a_d     = bus.in_a;
                s1_b_d     = bus.in_b;
                s1_cls_a_d = cls_in[0];
                s1_cls_b_d = cls_in[1];
            end
        end
        // Result registers hold while stalled so the output stays stable
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d = ovr_result;
                s2_flags_d  = ovr_flags;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_cls_a_q  <= '0;
            s1_cls_b_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_flags_q  <= '0;
            op_count_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_cls_a_q  <= s1_cls_a_d;
            s1_cls_b_q  <= s1_cls_b_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_flags_q  <= s2_flags_d;
            op_count_q  <= op_count_d;
        end
    end

    assign bus.out_valid  = s2_valid_q;
    assign bus.out_result = s2_result_q;
    assign bus.out_flags  = s2_flags_q;
    assign bus.op_count   = op_count_q;

`ifdef FP_MUL_STICKY_FLAGS_EN
    logic [3:0] sticky_q, sticky_d;

    // A result handed off in the same cycle as a clear still lands in the register
    always_comb begin
        sticky_d = bus.flag_clr ? 4'd0 : sticky_q;
        if (out_xfer) begin
            sticky_d = sticky_d | s2_flags_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 4'd0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign bus.sticky_flags = sticky_q;
`else
    logic unused_flag_clr;
    assign unused_flag_clr  = bus.flag_clr;
    assign bus.sticky_flags = 4'd0;
`endif
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed + random scoreboard bench for fp_mul_pipe (CNT_W = 8 to exercise counter wrap).
module tb_fp_mul_pipe;
    localparam int CW = 8;

    typedef struct packed {
        logic [3:0]  flags;
        logic [31:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_mul_pipe_if #(.DATA_W(32), .CNT_W(CW)) bus ();
    fp_mul_pipe #(.DATA_W(32), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    int            popped = 0;
    int            pushed = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic [3:0]    exp_sticky = 4'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference for normal x normal: exact product in double precision, then one RNE rounding to single
    function automatic logic [31:0] real_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] da, db, pb;
        real         p;
        int          e;
        logic [23:0] m;
        logic        g, st;
        da = {a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'd0};
        db = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
        p  = $bitstoreal(da) * $bitstoreal(db);
        pb = $realtobits(p);
        e  = int'(pb[62:52]) - 896;
        m  = {1'b0, pb[51:29]};
        g  = pb[28];
        st = |pb[27:0];
        if (g && (st || m[0])) m = m + 24'd1;
        if (m[23]) begin
            e = e + 1;
            m = 24'd0;
        end
        if (e >= 255) return {pb[63], 31'h7F800000};
        if (e <= 0) return {pb[63], 31'd0};
        return {pb[63], 8'(e), m[22:0]};
    endfunction

    function automatic exp_t ref_mul(input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        logic an, bn, ai, bi, az, bz, s;
        an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        az = (a[30:0] == 31'd0);
        bz = (b[30:0] == 31'd0);
        s  = a[31] ^ b[31];
        r.flags = 4'd0;
        r.res   = 32'd0;
        if (an || bn) begin
            r.res = 32'h7FC00000; r.flags = 4'b1001;
        end else if ((az && bi) || (ai && bz)) begin
            r.res = 32'h7FC00000; r.flags = 4'b0001;
        end else if (ai || bi) begin
            r.res = {s, 31'h7F800000}; r.flags = 4'b0010;
        end else if (az || bz) begin
            r.res = {s, 31'd0}; r.flags = 4'b0100;
        end else begin
            r.res = real_mul(a, b);
            if (r.res[30:0] == 31'd0) r.flags = 4'b0100;
            else if (r.res[30:0] == 31'h7F800000) r.flags = 4'b0010;
        end
        return r;
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        int          k;
        v = $urandom();
        k = int'($urandom_range(0, 19));
        if (k == 0) v[30:0] = 31'd0;
        else if (k == 1) v[30:0] = 31'h7F800000;
        else if (k == 2) begin
            v[30:23] = 8'hFF;
            v[22]    = 1'b1;
        end else v[30:23] = 8'($urandom_range(100, 154));
        return v;
    endfunction

    // Scoreboard: push on input transfer, pop/compare on output transfer
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            exp_cnt    = '0;
            exp_sticky = 4'd0;
        end else begin
            chk("op_count", 32'(bus.op_count), 32'(exp_cnt));
            chk("sticky_flags", 32'(bus.sticky_flags), 32'(exp_sticky));
`ifdef FP_MUL_STICKY_FLAGS_EN
            if (bus.flag_clr) exp_sticky = 4'd0;
`endif
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_output: observed %h expected no result", bus.out_result);
                end else begin
                    e = sb.pop_front();
                    popped++;
                    $display("out %0d: result=%h flags=%b expected=%h/%b", popped,
                             bus.out_result, bus.out_flags, e.res, e.flags);
                    chk("result", bus.out_result, e.res);
                    chk("flags", 32'(bus.out_flags), 32'(e.flags));
`ifdef FP_MUL_STICKY_FLAGS_EN
                    exp_sticky = exp_sticky | e.flags;
`endif
                end
                exp_cnt = exp_cnt + 1'b1;
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(ref_mul(bus.in_a, bus.in_b));
                pushed++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: observed in_ready=0 expected 1 within 200 cycles");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   sent;
        logic pend, acc;
        logic [3:0] stk_exp;

        bus.in_valid  = 1'b0;
        bus.in_a      = 32'd0;
        bus.in_b      = 32'd0;
        bus.out_ready = 1'b0;
        bus.flag_clr  = 1'b0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_result", bus.out_result, 32'd0);
        chk("rst_out_flags", 32'(bus.out_flags), 32'd0);
        chk("rst_sticky", 32'(bus.sticky_flags), 32'd0);
        chk("rst_op_count", 32'(bus.op_count), 32'd0);
        @(posedge clk);
        #1;

        // 1 x -1, latency and first count
        bus.out_ready = 1'b1;
        send(32'h3F800000, 32'hBF800000);
        chk("no_early_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_result", bus.out_result, 32'hBF800000);
        chk("lat_flags", 32'(bus.out_flags), 32'd0);
        @(posedge clk);
        #1;
        chk("op_count_first", 32'(bus.op_count), 32'd1);

        // 0 x inf invalid, then sticky clear
        send(32'h00000000, 32'h7F800000);
        @(posedge clk);
        #1;
        chk("zinf_result", bus.out_result, 32'h7FC00000);
        chk("zinf_flags", 32'(bus.out_flags), 32'h1);
        @(posedge clk);
        #1;
`ifdef FP_MUL_STICKY_FLAGS_EN
        stk_exp = 4'b0001;
`else
        stk_exp = 4'b0000;
`endif
        chk("sticky_set", 32'(bus.sticky_flags), 32'(stk_exp));
        bus.flag_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.flag_clr = 1'b0;
        chk("sticky_cleared", 32'(bus.sticky_flags), 32'd0);

        // NaN operand and signed zero, back to back
        send(32'h7FC00000, 32'h40000000);
        send(32'h80000000, 32'h40000000);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: two absorbed, third stalls
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = 32'h3F800000;
        bus.in_b      = 32'h40000000;
        @(negedge clk);
        chk("bp_ready_1", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_a = 32'hBF800000;
        @(negedge clk);
        chk("bp_ready_2", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_a = 32'h40490FDB;
        @(negedge clk);
        chk("bp_ready_full", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_still_full", 32'(bus.in_ready), 32'd0);
        chk("bp_stable_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_stable_result", bus.out_result, 32'h40000000);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(32'h40490FDB, 32'h40000000);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_drained", 32'(sb.size()), 32'd0);

        // Random valid/ready traffic, 1000 pairs; op_count wraps several times
        sent = 0;
        pend = 1'b0;
        for (int cyc = 0; cyc < 20000 && (sent < 1000 || sb.size() != 0); cyc++) begin
            if (!pend && sent < 1000 && $urandom_range(0, 3) != 0) begin
                bus.in_a     = rnd_op();
                bus.in_b     = rnd_op();
                bus.in_valid = 1'b1;
                pend         = 1'b1;
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                pend         = 1'b0;
                sent++;
                bus.in_valid = 1'b0;
            end
        end
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rand_sent", 32'(sent), 32'd1000);
        chk("rand_drained", 32'(sb.size()), 32'd0);
        chk("rand_no_loss", 32'(popped), 32'(pushed));

        // Reset with both stages full
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = 32'h40400000;
        bus.in_b      = 32'h40000000;
        @(posedge clk);
        #1;
        bus.in_a = 32'hC0400000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("full_out_valid", 32'(bus.out_valid), 32'd1);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_async_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_rst_op_count", 32'(bus.op_count), 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("no_stale_output", 32'(bus.out_valid), 32'd0);
        end
        send(32'h40400000, 32'h40000000);
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_drained", 32'(sb.size()), 32'd0);
        chk("post_rst_count", 32'(bus.op_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

Two-stage pipelined, flow-controlled wrapper around the combinational `fp_multiplier` (IEEE-754 single precision). Stage 1 registers the operands and classifies them. The multiplier evaluates between the stages. Stage 2 registers the product, overrides special cases and produces status flags. It sits between the FPALU operand issue logic and the result writeback, using valid/ready on both sides.

## Interface
- `DATA_W`, 32: operand/result width; only 32 is supported.
- `CNT_W`, 16: width of the completed-operation counter.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  pipe accepts operands this cycle.
- `in_a`, `in_b`  in  32  IEEE-754 operands.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts result.
- `out_result`  out  32  product.
- `out_flags`  out  4  per-result flags: [0] invalid, [1] infinite, [2] zero, [3] NaN operand.
- `flag_clr`  in  1  clears sticky flags.
- `sticky_flags`  out  4  OR-accumulated `out_flags` of every handed-off result.
- `op_count`  out  CNT_W  number of results handed off (`out_valid && out_ready`).

## Operation
- **Transfer rules**
  - Input transfer: `in_valid && in_ready`.
  - Output transfer: `out_valid && out_ready`.
- **Stage 1** holds `s1_valid`, `s1_a`, `s1_b`, and class bits per operand: zero, inf, NaN.
  - Exponent 0xFF with mantissa ≠ 0 is NaN.
  - Exponent 0xFF with mantissa = 0 is inf.
  - Exponent 0 with mantissa = 0 is zero.
- **Stage 2** holds `s2_valid`, result and flags. It is loaded from `fp_multiplier(s1_a, s1_b)` with overrides, applied in priority order:
  1. Any NaN operand → 0x7FC00000, flags invalid + NaN.
  2. Zero × inf → 0x7FC00000, flag invalid.
  3. Any inf → sign = `a[31]^b[31]`, value 0x7F800000 (with that sign), flag infinite.
  4. Any zero → signed zero (sign xor), flag zero.
  5. Otherwise → raw multiplier result; flag zero set if its magnitude bits are 0, flag infinite if they equal 0x7F800000.
- **Advance and ready logic**
  - `s2_adv = !s2_valid || out_ready`.
  - `s1_adv = !s1_valid || s2_adv`.
  - `in_ready = s1_adv` (combinational).
  - Full throughput: one result per cycle with no bubbles while `out_ready` stays high.
- **Ordering and stability**
  - Results leave strictly in acceptance order.
  - Nothing is dropped or duplicated under any backpressure pattern.
  - `out_result`/`out_flags` are stable while `out_valid && !out_ready`.
- **op_count**
  - Increments on each output transfer.
  - Wraps modulo 2^CNT_W from max to 0.
- **Reset values**
  - All valids, `out_result`, `out_flags`, `sticky_flags` and `op_count` are 0.
  - `in_ready` is 1 after reset.
  - Reset mid-operation discards in-flight operands; no partial output appears.

## Timing
- Latency: operands accepted at edge N appear with `out_valid` = 1 after edge N+1, provided stage 2 is free.
- Backpressure: with `out_ready` held low, two operand pairs are absorbed. After that `in_ready` = 0 until an output transfer.
- Simultaneous events in the same cycle:
  - An output transfer and an input transfer both complete; occupancy is unchanged.
  - `flag_clr` together with a flagged output transfer: `sticky_flags` = that result's flags (set wins over clear).
- No combinational path from `in_valid` to `out_valid`. `in_ready` depends combinationally on `out_ready`.

## Configuration
- `FP_MUL_STICKY_FLAGS_EN`
  - Defined: `sticky_flags` register and `flag_clr` function as described.
  - Undefined: no sticky register is built, `sticky_flags` is constant 0 and `flag_clr` is ignored.
- `out_flags` and `op_count` are present in both configurations.

## Structure
- Shared package `fp_pkg` holds:
  - Constants `FP_QNAN` = 32'h7FC00000 and `FP_INF_MAG` = 31'h7F800000, plus exponent/mantissa field widths.
  - Flag bit indices `FLG_INVALID`, `FLG_INF`, `FLG_ZERO`, `FLG_NAN`.
  - A typedef for the 3-bit operand class.
- Sub-module `fp_classify`: one operand in, class bits out, instantiated twice.
- The existing `fp_multiplier` is instantiated unchanged.

## Test plan
- 0x3F800000 × 0xBF800000 with `out_ready` = 1 → 0xBF800000 after edge N+1, flags 0, `op_count` = 1.
- 0x00000000 × 0x7F800000 → 0x7FC00000, `out_flags` = 4'b0001. A following `flag_clr` pulse returns `sticky_flags` to 0.
- 0x7FC00000 × 0x40000000 → 0x7FC00000, flags 4'b1001. 0x80000000 × 0x40000000 → 0x80000000, flags 4'b0100.
- Three back-to-back pairs (1×2, −1×2, 3.14×2) with `out_ready` = 0:
  - `in_ready` falls after 2 acceptances.
  - Raising `out_ready` yields 0x40000000, 0xC0000000, 0x40C90FDB in order.
- Random valid/ready toggling over 1000 pairs: scoreboard against a reference multiply, in-order, no loss. With CNT_W = 8, `op_count` wraps 255 → 0.
- Assert `rst` while both stages are full: `out_valid` = 0 immediately, `in_ready` = 1 after release, and no stale result appears afterwards.
